// File: rtl/md5_pkg.sv
// Shared state encoding and block-geometry constants
// for the MD5 message front end.
package md5_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        SEND,
        WAIT
    } md5_state_e;

    localparam logic [7:0] MD5_PAD_BYTE    = 8'h80;
    localparam int         MD5_BLOCK_BYTES = 64;
    localparam int         MD5_LEN_OFFSET  = 56;
    localparam int         MD5_CHUNKS      = 4;

endpackage

// File: rtl/md5_blockbuf.sv
// 64-byte block buffer: byte write port, masked zero/pad/length
// port, and a 128-bit chunk read mux in little-endian word order.
module md5_blockbuf
    import md5_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [5:0]   wr_idx,
    input  logic [7:0]   wr_byte,
    input  logic         pad_en,
    input  logic [6:0]   pad_idx,
    input  logic         mark_en,
    input  logic         len_en,
    input  logic [63:0]  len,
    input  logic [1:0]   chunk_sel,
    output logic [127:0] chunk
);

    logic [7:0] mem [MD5_BLOCK_BYTES];

    // Later writes in the same cycle take priority: zero, then 0x80, then length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < MD5_BLOCK_BYTES; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MD5_BLOCK_BYTES; k++) begin
                if (wr_en && wr_idx == 6'(k)) begin
                    mem[k] <= wr_byte;
                end
                if (pad_en && 7'(k) >= pad_idx) begin
                    mem[k] <= '0;
                end
                if (mark_en && 7'(k) == pad_idx) begin
                    mem[k] <= MD5_PAD_BYTE;
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (len_en) begin
                    mem[MD5_LEN_OFFSET + i] <= len[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        chunk = '0;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                chunk[96 - 32*w + 8*b +: 8] = mem[{chunk_sel, 2'(w), 2'(b)}];
            end
        end
    end

endmodule

// File: rtl/md5_padder.sv
// Byte-stream front end for the md5 core: packs, pads and
// hands each 512-bit block over as four 128-bit loads.
module md5_padder
    import md5_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         empty_i,
    input  logic         byte_valid_i,
    input  logic [7:0]   byte_i,
    input  logic         last_i,
    output logic         byte_ready_o,
    output logic         newtext_o,
    output logic         load_o,
    output logic [127:0] data_o,
    input  logic         hash_ready_i,
    output logic         done_o,
    output logic         busy_o
);

    md5_state_e  state, state_nxt;
    logic [6:0]  idx, idx_nxt;
    logic [63:0] bit_len, bit_len_nxt;
    logic        pad80, pad80_nxt;
    logic        last_blk, last_blk_nxt;
    logic        pend, pend_nxt;
    logic [1:0]  chunk_cnt, chunk_cnt_nxt;
    logic        newtext_nxt, done_nxt;
    logic        xfer, pad_en, mark_en, len_en;
    logic [6:0]  free_idx;
    logic [127:0] chunk;

    assign byte_ready_o = (state == FILL);
    assign busy_o       = (state != IDLE);
    assign load_o       = (state == SEND);
    assign data_o       = load_o ? chunk : '0;

    assign xfer     = byte_ready_o && byte_valid_i;
    assign pad_en   = (state == PAD);
    assign mark_en  = pad_en && !pad80 && (idx <= 7'(MD5_BLOCK_BYTES - 1));
    // Length fits only if the byte after the 0x80 marker is at or below the length field.
    assign free_idx = pad80 ? idx : idx + 7'd1;
    assign len_en   = pad_en && (free_idx <= 7'(MD5_LEN_OFFSET));

    md5_blockbuf u_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (xfer),
        .wr_idx    (idx[5:0]),
        .wr_byte   (byte_i),
        .pad_en    (pad_en),
        .pad_idx   (idx),
        .mark_en   (mark_en),
        .len_en    (len_en),
        .len       (bit_len),
        .chunk_sel (chunk_cnt),
        .chunk     (chunk)
    );

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        bit_len_nxt   = bit_len;
        pad80_nxt     = pad80;
        last_blk_nxt  = last_blk;
        pend_nxt      = pend;
        chunk_cnt_nxt = chunk_cnt;
        newtext_nxt   = 1'b0;
        done_nxt      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    idx_nxt      = '0;
                    bit_len_nxt  = '0;
                    pad80_nxt    = 1'b0;
                    last_blk_nxt = 1'b0;
                    pend_nxt     = 1'b0;
                    newtext_nxt  = 1'b1;
                    state_nxt    = empty_i ? PAD : FILL;
                end
            end
            FILL: begin
                if (xfer) begin
                    idx_nxt     = idx + 7'd1;
                    bit_len_nxt = bit_len + 64'd8;
                    if (idx == 7'(MD5_BLOCK_BYTES - 1)) begin
                        state_nxt     = SEND;
                        chunk_cnt_nxt = '0;
                        pend_nxt      = last_i;
                    end else if (last_i) begin
                        state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                if (!pad80) begin
                    pad80_nxt = 1'b1;
                end
                if (len_en) begin
                    last_blk_nxt = 1'b1;
                end
                chunk_cnt_nxt = '0;
                state_nxt     = SEND;
            end
            SEND: begin
                chunk_cnt_nxt = chunk_cnt + 2'd1;
                if (chunk_cnt == 2'(MD5_CHUNKS - 1)) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (hash_ready_i) begin
                    if (last_blk) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (pend || pad80) begin
                        pend_nxt  = 1'b0;
                        idx_nxt   = '0;
                        state_nxt = PAD;
                    end else begin
                        idx_nxt   = '0;
                        state_nxt = FILL;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            bit_len   <= '0;
            pad80     <= 1'b0;
            last_blk  <= 1'b0;
            pend      <= 1'b0;
            chunk_cnt <= '0;
            newtext_o <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            bit_len   <= bit_len_nxt;
            pad80     <= pad80_nxt;
            last_blk  <= last_blk_nxt;
            pend      <= pend_nxt;
            chunk_cnt <= chunk_cnt_nxt;
            newtext_o <= newtext_nxt;
            done_o    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_md5_padder.sv
// Directed bench for md5_padder: table of messages with
// hand-computed chunks plus backpressure and reset sequences.
module tb_md5_padder;

    logic         clk;
    logic         reset;
    logic         start_i;
    logic         empty_i;
    logic         byte_valid_i;
    logic [7:0]   byte_i;
    logic         last_i;
    logic         byte_ready_o;
    logic         newtext_o;
    logic         load_o;
    logic [127:0] data_o;
    logic         hash_ready_i;
    logic         done_o;
    logic         busy_o;

    md5_padder dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .empty_i      (empty_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .last_i       (last_i),
        .byte_ready_o (byte_ready_o),
        .newtext_o    (newtext_o),
        .load_o       (load_o),
        .data_o       (data_o),
        .hash_ready_i (hash_ready_i),
        .done_o       (done_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           len;
        bit           abc;
        int           nblk;
        logic [127:0] c3_first;
        logic [127:0] c0_last;
        logic [127:0] c3_last;
    } vec_t;

    vec_t         tbl [8];
    int           n_chk = 0;
    int           n_pass = 0;
    int           cyc = 0;
    logic [127:0] cap [$];
    int           done_cnt, nt_cnt, hr_cnt;
    int           first_ld, nt_cyc, done_cyc, hr_cyc;
    int           start_cyc, last_xfer;
    int           rdy_delay = 0;
    int           timer = -1;
    int           ld_run = 0;
    logic [7:0]   msg [0:127];
    logic [7:0]   pm [0:191];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (load_o) begin
                cap.push_back(data_o);
                if (first_ld < 0) first_ld = cyc;
            end
            if (newtext_o) begin
                nt_cnt++;
                nt_cyc = cyc;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Stand-in for md5.ready_o: pulses rdy_delay cycles after a 4-load block.
    initial begin : responder
        hash_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            hash_ready_i = 1'b0;
            if (!reset) begin
                ld_run = 0;
                timer  = -1;
            end else if (load_o) begin
                ld_run++;
                if (ld_run == 4) begin
                    ld_run = 0;
                    timer  = rdy_delay;
                end
            end else if (timer > 0) begin
                timer--;
            end else if (timer == 0) begin
                hash_ready_i = 1'b1;
                hr_cyc = cyc;
                hr_cnt++;
                timer = -1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: got timeout required event", name);
    endtask

    task automatic begin_msg(input int n, input bit abc);
        int g;
        cap.delete();
        done_cnt = 0; nt_cnt = 0; hr_cnt = 0;
        first_ld = -1; nt_cyc = -1; done_cyc = -1; last_xfer = -1;
        for (int i = 0; i < n; i++) msg[i] = abc ? 8'(8'h61 + i) : 8'(i + 1);
        @(negedge clk);
        start_i = 1'b1;
        empty_i = (n == 0);
        start_cyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
        empty_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            byte_valid_i = 1'b1;
            byte_i = msg[i];
            last_i = (i == n - 1);
            g = 0;
            while (!byte_ready_o && g < 500) begin
                @(negedge clk);
                g++;
            end
            if (g >= 500) begin
                fail_now("byte_ready");
                break;
            end
            last_xfer = cyc;
            @(negedge clk);
        end
        byte_valid_i = 1'b0;
        last_i = 1'b0;
    endtask

    function automatic logic [127:0] model_chunk(input int b, input int j);
        logic [127:0] c;
        logic [31:0]  wd;
        c = '0;
        for (int w = 4*j; w < 4*j + 4; w++) begin
            wd = {pm[b*64 + 4*w + 3], pm[b*64 + 4*w + 2],
                  pm[b*64 + 4*w + 1], pm[b*64 + 4*w]};
            c = {c[95:0], wd};
        end
        return c;
    endfunction

    task automatic finish_msg(input int v);
        int n, nb, g;
        logic [63:0] l;
        n  = tbl[v].len;
        nb = tbl[v].nblk;
        g  = 0;
        while (done_cnt == 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (done_cnt == 0) fail_now($sformatf("done v%0d", v));
        repeat (2) @(negedge clk);
        for (int i = 0; i < 192; i++) pm[i] = 8'h00;
        for (int i = 0; i < n; i++) pm[i] = msg[i];
        pm[n] = 8'h80;
        l = 64'(n) * 64'd8;
        for (int i = 0; i < 8; i++) pm[nb*64 - 8 + i] = l[8*i +: 8];
        check($sformatf("v%0d load_count", v), 128'(cap.size()), 128'(4*nb));
        if (cap.size() == 4*nb) begin
            for (int k = 0; k < 4*nb; k++)
                check($sformatf("v%0d chunk%0d", v, k), cap[k], model_chunk(k/4, k%4));
            check($sformatf("v%0d c3_first", v), cap[3], tbl[v].c3_first);
            check($sformatf("v%0d c0_last", v), cap[4*(nb-1)], tbl[v].c0_last);
            check($sformatf("v%0d c3_last", v), cap[4*nb-1], tbl[v].c3_last);
        end
        check($sformatf("v%0d done_count", v), 128'(done_cnt), 128'd1);
        check($sformatf("v%0d newtext_count", v), 128'(nt_cnt), 128'd1);
        check($sformatf("v%0d newtext_cycle", v), 128'(nt_cyc), 128'(start_cyc + 1));
        check($sformatf("v%0d done_cycle", v), 128'(done_cyc), 128'(hr_cyc + 1));
        if (n > 0 && n <= 64)
            check($sformatf("v%0d load_latency", v), 128'(first_ld),
                  128'(last_xfer + ((n == 64) ? 1 : 2)));
    endtask

    initial begin : main
        int g, bp_viol;
        reset = 1'b0;
        start_i = 1'b0; empty_i = 1'b0;
        byte_valid_i = 1'b0; byte_i = 8'h00; last_i = 1'b0;

        tbl[0] = '{3,  1'b1, 1, 128'h00000000_00000000_00000018_00000000,
                   128'h80636261_00000000_00000000_00000000,
                   128'h00000000_00000000_00000018_00000000};
        tbl[1] = '{0,  1'b0, 1, 128'h0,
                   128'h00000080_00000000_00000000_00000000, 128'h0};
        tbl[2] = '{1,  1'b0, 1, 128'h00000000_00000000_00000008_00000000,
                   128'h00008001_00000000_00000000_00000000,
                   128'h00000000_00000000_00000008_00000000};
        tbl[3] = '{55, 1'b0, 1, 128'h34333231_80373635_000001b8_00000000,
                   128'h04030201_08070605_0c0b0a09_100f0e0d,
                   128'h34333231_80373635_000001b8_00000000};
        tbl[4] = '{56, 1'b0, 2, 128'h34333231_38373635_00000080_00000000,
                   128'h0, 128'h00000000_00000000_000001c0_00000000};
        tbl[5] = '{63, 1'b0, 2, 128'h34333231_38373635_3c3b3a39_803f3e3d,
                   128'h0, 128'h00000000_00000000_000001f8_00000000};
        tbl[6] = '{64, 1'b0, 2, 128'h34333231_38373635_3c3b3a39_403f3e3d,
                   128'h00000080_00000000_00000000_00000000,
                   128'h00000000_00000000_00000200_00000000};
        tbl[7] = '{65, 1'b0, 2, 128'h34333231_38373635_3c3b3a39_403f3e3d,
                   128'h00008041_00000000_00000000_00000000,
                   128'h00000000_00000000_00000208_00000000};

        #3;
        check("reset_ctrl", 128'({byte_ready_o, newtext_o, load_o, done_o, busy_o}), 128'd0);
        check("reset_data", data_o, 128'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", 128'(busy_o), 128'd0);

        for (int v = 0; v < 8; v++) begin
            begin_msg(tbl[v].len, tbl[v].abc);
            finish_msg(v);
        end

        // Backpressure: long hash_ready delay, start_i toggled while waiting.
        rdy_delay = 200;
        begin_msg(3, 1'b1);
        g = 0;
        while (timer <= 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (timer <= 0) fail_now("bp_wait_entry");
        bp_viol = 0;
        repeat (150) begin
            @(negedge clk);
            start_i = ~start_i;
            empty_i = 1'b1;
            if (byte_ready_o || load_o || !busy_o) bp_viol++;
        end
        start_i = 1'b0;
        empty_i = 1'b0;
        check("bp_violations", 128'(bp_viol), 128'd0);
        finish_msg(0);
        rdy_delay = 0;

        // Reset dropped in the middle of SEND aborts the message.
        begin_msg(3, 1'b1);
        g = 0;
        while (!load_o && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!load_o) fail_now("send_entry");
        #2 reset = 1'b0;
        #1;
        check("rst_mid_ctrl", 128'({byte_ready_o, newtext_o, load_o, done_o, busy_o}), 128'd0);
        check("rst_mid_data", data_o, 128'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_done", 128'(done_cnt), 128'd0);
        begin_msg(3, 1'b1);
        finish_msg(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
